dm_lsu: RTL

- Parametrised data memory for the single-cycle/pipelined MIPS core; successor to the word/byte-store data memory.
- Full load/store set: LW/LH/LHU/LB/LBU/SW/SH/SB.
- Byte-lane merge; sign/zero extension done inside the block.
- Alignment and range exceptions.
- Configurable read latency behind a valid/ready handshake.
- Hardware clear sweep after reset instead of a one-cycle bulk clear.

---
 rtl/dm_pkg.sv | 49 ++++
 rtl/dm_lane.sv | 58 +++++
 rtl/dm_lsu.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory load/store unit: access size codes,
// exception codes, controller states and small decode helpers.
package dm_pkg;

  // Access size / sign code carried on req_op
  typedef enum logic [2:0] {
    OP_W  = 3'd0,
    OP_B  = 3'd1,
    OP_H  = 3'd2,
    OP_BU = 3'd3,
    OP_HU = 3'd4
  } op_e;

  // Completion status reported on resp_exc
  typedef enum logic [1:0] {
    EXC_NONE  = 2'd0,
    EXC_ALIGN = 2'd1,
    EXC_RANGE = 2'd2
  } exc_e;

  // Controller states
  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  // Unused encodings 5..7 behave as a full-word access
  function automatic op_e norm_op(input logic [2:0] code);
    case (code)
      3'd1:    return OP_B;
      3'd2:    return OP_H;
      3'd3:    return OP_BU;
      3'd4:    return OP_HU;
      default: return OP_W;
    endcase
  endfunction

  // Words need a 4-byte boundary, halves a 2-byte boundary, bytes never fault
  function automatic logic misaligned(input op_e op, input logic [1:0] off);
    case (op)
      OP_W:        return off != 2'b00;
      OP_H, OP_HU: return off[0];
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dm_lane.sv
// Byte-lane datapath shared by stores and loads: merges store data into the
// old word and extracts/extends the addressed byte or half for loads.
module dm_lane
  import dm_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  op_e         op,
  input  logic [1:0]  off,
  output logic [31:0] new_word,
  output logic [31:0] rdata
);

  logic [3:0]  be;
  logic [31:0] wsrc;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Lane enables and store data replicated across lanes for the access size
  always_comb begin
    be   = 4'b1111;
    wsrc = wdata;
    case (op)
      OP_B, OP_BU: begin
        be   = 4'b0001 << off;
        wsrc = {4{wdata[7:0]}};
      end
      OP_H, OP_HU: begin
        be   = off[1] ? 4'b1100 : 4'b0011;
        wsrc = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Each byte lane takes new data when enabled, otherwise keeps its old value
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign new_word[8*gi +: 8] = be[gi] ? wsrc[8*gi +: 8] : old_word[8*gi +: 8];
    end
  endgenerate

  assign sel_byte = old_word[{off, 3'b000} +: 8];
  assign sel_half = old_word[{off[1], 4'b0000} +: 16];

  // Load extraction with sign or zero extension
  always_comb begin
    case (op)
      OP_B:    rdata = {{24{sel_byte[7]}}, sel_byte};
      OP_BU:   rdata = {24'h000000, sel_byte};
      OP_H:    rdata = {{16{sel_half[15]}}, sel_half};
      OP_HU:   rdata = {16'h0000, sel_half};
      default: rdata = old_word;
    endcase
  end

endmodule

// File: rtl/dm_lsu.sv
// Data memory with full MIPS load/store set, alignment/range exceptions,
// configurable read latency and a post-reset hardware clear sweep.
module dm_lsu
  import dm_pkg::*;
#(
  parameter int          DEPTH     = 3072,
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int          RD_LAT    = 1,
  parameter bit          TRACE     = 1
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_exc,
  output logic        init_busy
);

  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WAIT_W = (RD_LAT > 2) ? $clog2(RD_LAT - 1) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'((RD_LAT > 1) ? RD_LAT - 2 : 0);

  logic [31:0] mem [DEPTH];

  state_e            state_reg;
  logic [IDX_W-1:0]  sweep_cnt_reg;
  logic [IDX_W-1:0]  idx_reg;
  op_e               op_reg;
  logic [1:0]        off_reg;
  logic [WAIT_W-1:0] wait_cnt_reg;

  // Request decode: word offset from the base, with the borrow flagging
  // addresses below the base
  logic              below_base;
  logic [29:0]       word_off;
  logic              out_range;
  op_e               req_op_n;
  exc_e              req_exc;
  logic [IDX_W-1:0]  req_idx;

  assign {below_base, word_off} = {1'b0, req_addr[31:2]} - {1'b0, ADDR_BASE[31:2]};
  assign out_range = below_base || (word_off >= 30'(DEPTH));
  assign req_op_n  = norm_op(req_op);
  assign req_exc   = misaligned(req_op_n, req_addr[1:0]) ? EXC_ALIGN :
                     (out_range ? EXC_RANGE : EXC_NONE);
  assign req_idx   = word_off[IDX_W-1:0];

  // Lane datapath sees the live request in IDLE and the latched load in WAIT
  logic [IDX_W-1:0] rd_idx;
  op_e              lane_op;
  logic [1:0]       lane_off;
  logic [31:0]      lane_old;
  logic [31:0]      lane_new;
  logic [31:0]      lane_rdata;

  assign rd_idx   = (state_reg == WAIT) ? idx_reg : req_idx;
  assign lane_op  = (state_reg == WAIT) ? op_reg  : req_op_n;
  assign lane_off = (state_reg == WAIT) ? off_reg : req_addr[1:0];
  assign lane_old = mem[rd_idx];

  dm_lane u_lane (
    .old_word (lane_old),
    .wdata    (req_wdata),
    .op       (lane_op),
    .off      (lane_off),
    .new_word (lane_new),
    .rdata    (lane_rdata)
  );

  logic store_commit;
  logic sweep_we;

  assign store_commit = !Reset && (state_reg == IDLE) && req_valid && req_we &&
                        (req_exc == EXC_NONE);
  assign sweep_we     = !Reset && (state_reg == INIT);

  // Memory write port: the clear sweep writes zero, committed stores write the merged word
  always_ff @(posedge clk) begin
    if (sweep_we)
      mem[sweep_cnt_reg] <= '0;
    else if (store_commit)
      mem[req_idx] <= lane_new;
  end

  // Controller: sweep, accept, optional read wait, one-cycle response
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_reg     <= INIT;
      sweep_cnt_reg <= '0;
      idx_reg       <= '0;
      op_reg        <= OP_W;
      off_reg       <= 2'b00;
      wait_cnt_reg  <= '0;
      req_ready     <= 1'b0;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      resp_exc      <= EXC_NONE;
      init_busy     <= 1'b1;
    end else begin
      case (state_reg)
        INIT: begin
          if (sweep_cnt_reg == LAST_IDX) begin
            state_reg <= IDLE;
            init_busy <= 1'b0;
            req_ready <= 1'b1;
          end else begin
            sweep_cnt_reg <= sweep_cnt_reg + 1'b1;
          end
        end
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            resp_exc  <= req_exc;
            if (req_we || (req_exc != EXC_NONE)) begin
              state_reg  <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= '0;
            end else if (RD_LAT == 1) begin
              state_reg  <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= lane_rdata;
            end else begin
              state_reg    <= WAIT;
              idx_reg      <= req_idx;
              op_reg       <= req_op_n;
              off_reg      <= req_addr[1:0];
              wait_cnt_reg <= '0;
            end
          end
        end
        WAIT: begin
          if (wait_cnt_reg == LAST_WAIT) begin
            state_reg  <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= lane_rdata;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end
        RESP: begin
          state_reg  <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_rdata <= '0;
          resp_exc   <= EXC_NONE;
        end
        default: state_reg <= INIT;
      endcase
    end
  end

`ifndef SYNTHESIS
  generate
    if (TRACE) begin : g_trace
      // Store trace: one line per committed store showing the merged word
      always_ff @(posedge clk) begin
        if (store_commit)
          $display("%d@%h: *%h <= %h", $time, req_pc, req_addr, lane_new);
      end
    end
  endgenerate
`endif

endmodule
